// File: rtl/opl3_write_sequencer.sv
// OPL3 write sequencer: queues decoded 0x388-0x38B byte writes and issues paced
// 9-bit register writes to the OPL3 register file.
module opl3_write_sequencer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned WR_GAP     = 36
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [1:0] in_port,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       wr_en,
    output logic [8:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] overflow_cnt
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } state_t;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [7:0]    r_ovf;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [8:0]    r_latch;
    logic [8:0]    w_latch_nxt;
    logic [8:0]    r_wr_addr;
    logic [8:0]    w_wr_addr_nxt;
    logic [7:0]    r_wr_data;
    logic [7:0]    w_wr_data_nxt;
    logic [GW-1:0] r_gap;
    logic [GW-1:0] w_gap_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [9:0]    w_head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
    assign w_push  = in_valid && !w_full;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_port, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (in_valid && w_full && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_latch   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_gap     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_latch   <= w_latch_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_gap     <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_latch_nxt   = r_latch;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_gap_nxt     = r_gap;
        w_pop         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    // Odd ports carry data; bank always comes from the address port.
                    if (w_head[8]) begin
                        w_wr_addr_nxt = r_latch;
                        w_wr_data_nxt = w_head[7:0];
                        w_state_nxt   = S_ISSUE;
                    end else begin
                        w_latch_nxt = {w_head[9], w_head[7:0]};
                    end
                end
            end
            S_ISSUE: begin
                if (WR_GAP == 0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt   = GW'(WR_GAP - 1);
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready     = !w_full;
    assign wr_en        = (r_state == S_ISSUE);
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign busy         = !w_empty || (r_state != S_IDLE);
    assign overflow_cnt = r_ovf;
endmodule

// File: tb/tb_opl3_write_sequencer.sv
// Bench for opl3_write_sequencer: two instances (WR_GAP=36 and WR_GAP=0) share the
// stimulus and are checked every cycle against a queue/timing model of the sequencer.
module tb_opl3_write_sequencer;
    localparam int DEPTH = 16;
    localparam int GAP0  = 36;
    localparam int GAP1  = 0;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic [1:0]      in_port;
    logic [7:0]      in_data;
    logic [1:0]      rdy;
    logic [1:0]      wen;
    logic [1:0][8:0] wa;
    logic [1:0][7:0] wd;
    logic [1:0]      bsy;
    logic [1:0][7:0] ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    opl3_write_sequencer #(.FIFO_DEPTH(DEPTH), .WR_GAP(GAP0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_port(in_port),
        .in_data(in_data), .in_ready(rdy[0]), .wr_en(wen[0]), .wr_addr(wa[0]),
        .wr_data(wd[0]), .busy(bsy[0]), .overflow_cnt(ovf[0])
    );

    opl3_write_sequencer #(.FIFO_DEPTH(DEPTH), .WR_GAP(GAP1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_port(in_port),
        .in_data(in_data), .in_ready(rdy[1]), .wr_en(wen[1]), .wr_addr(wa[1]),
        .wr_data(wd[1]), .busy(bsy[1]), .overflow_cnt(ovf[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: FIFO as a ring of entries, consumer as "earliest cycle it may pop next".
    logic [9:0] mq [2][64];
    int         cnt [2];
    int         head [2];
    logic [8:0] m_latch [2];
    logic [8:0] m_wa [2];
    logic [7:0] m_wd [2];
    logic [7:0] m_ovf [2];
    longint     nf [2];
    longint     iss [2];
    int         gapv [2];
    longint     cyc = 0;
    bit         m_valid = 1'b0;

    typedef struct {
        int         d;
        longint     t;
        logic [8:0] a;
        logic [7:0] v;
    } wr_t;
    wr_t wlog[$];

    function automatic int nlog(input int d);
        int n = 0;
        foreach (wlog[i]) if (wlog[i].d == d) n++;
        return n;
    endfunction

    task automatic getlog(input int d, input int k, output wr_t w);
        int n = 0;
        w = '{d: -1, t: -1, a: 9'h0, v: 8'h0};
        foreach (wlog[i]) begin
            if (wlog[i].d == d) begin
                if (n == k) w = wlog[i];
                n++;
            end
        end
    endtask

    always @(negedge clk) begin
        bit         was_full;
        logic [9:0] e;
        if (m_valid) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("wr_en[%0d]@%0d", d, cyc), 32'(wen[d]), 32'(iss[d] == cyc));
                chk($sformatf("wr_addr[%0d]@%0d", d, cyc), 32'(wa[d]), 32'(m_wa[d]));
                chk($sformatf("wr_data[%0d]@%0d", d, cyc), 32'(wd[d]), 32'(m_wd[d]));
                chk($sformatf("in_ready[%0d]@%0d", d, cyc), 32'(rdy[d]), 32'(cnt[d] < DEPTH));
                chk($sformatf("busy[%0d]@%0d", d, cyc), 32'(bsy[d]), 32'((cnt[d] > 0) || (cyc < nf[d])));
                chk($sformatf("overflow_cnt[%0d]@%0d", d, cyc), 32'(ovf[d]), 32'(m_ovf[d]));
                if (wen[d] === 1'b1) wlog.push_back('{d: d, t: cyc, a: wa[d], v: wd[d]});
            end
        end
        if (reset_n === 1'b0) begin
            for (int d = 0; d < 2; d++) begin
                cnt[d] = 0; head[d] = 0; m_latch[d] = '0; m_wa[d] = '0; m_wd[d] = '0;
                m_ovf[d] = '0; nf[d] = cyc + 1; iss[d] = -1;
            end
            gapv[0] = GAP0;
            gapv[1] = GAP1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int d = 0; d < 2; d++) begin
                was_full = (cnt[d] == DEPTH);
                if (in_valid && was_full && m_ovf[d] != 8'hFF) m_ovf[d] = m_ovf[d] + 8'd1;
                if (cyc >= nf[d] && cnt[d] > 0) begin
                    e = mq[d][head[d]];
                    head[d] = (head[d] + 1) % 64;
                    cnt[d]--;
                    if (e[8]) begin
                        m_wa[d] = m_latch[d];
                        m_wd[d] = e[7:0];
                        iss[d]  = cyc + 1;
                        nf[d]   = cyc + 2 + gapv[d];
                    end else begin
                        m_latch[d] = {e[9], e[7:0]};
                        nf[d]      = cyc + 1;
                    end
                end
                if (in_valid && !was_full) begin
                    mq[d][(head[d] + cnt[d]) % 64] = {in_port, in_data};
                    cnt[d]++;
                end
            end
        end
        cyc++;
    end

    task automatic drive(input logic v, input logic [1:0] p, input logic [7:0] dt, input logic rn);
        in_valid = v;
        in_port  = p;
        in_data  = dt;
        reset_n  = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        while (bsy !== 2'b00 && k < 2000) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1);
            k++;
        end
        if (bsy !== 2'b00) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: busy=%b still set after %0d cycles", bsy, k);
        end
    endtask

    initial begin
        longint pc;
        int     ndata;
        wr_t    w;
        logic [1:0] p;

        drive(1'b1, 2'd1, 8'hAA, 1'b0);
        drive(1'b1, 2'd1, 8'hAA, 1'b0);
        chk("reset in_ready", 32'(rdy), 32'h3);
        chk("reset busy", 32'(bsy), 32'h0);
        chk("reset wr_en", 32'(wen), 32'h0);
        chk("reset overflow0", 32'(ovf[0]), 32'h0);
        chk("reset overflow1", 32'(ovf[1]), 32'h0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);

        // Basic address/data pair
        wlog.delete();
        drive(1'b1, 2'd0, 8'hB0, 1'b1);
        pc = cyc;
        drive(1'b1, 2'd1, 8'h31, 1'b1);
        wait_idle();
        for (int d = 0; d < 2; d++) begin
            getlog(d, 0, w);
            chk($sformatf("pair count[%0d]", d), 32'(nlog(d)), 32'd1);
            chk($sformatf("pair latency[%0d]", d), 32'(w.t - pc), 32'd2);
            chk($sformatf("pair addr[%0d]", d), 32'(w.a), 32'h0B0);
            chk($sformatf("pair data[%0d]", d), 32'(w.v), 32'h31);
        end

        // Bank 1, both data ports write the latched bank
        wlog.delete();
        drive(1'b1, 2'd2, 8'h05, 1'b1);
        drive(1'b1, 2'd3, 8'h01, 1'b1);
        drive(1'b1, 2'd1, 8'h02, 1'b1);
        wait_idle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("bank1 count[%0d]", d), 32'(nlog(d)), 32'd2);
            getlog(d, 0, w);
            pc = w.t;
            chk($sformatf("bank1 addr0[%0d]", d), 32'(w.a), 32'h105);
            chk($sformatf("bank1 data0[%0d]", d), 32'(w.v), 32'h01);
            getlog(d, 1, w);
            chk($sformatf("bank1 addr1[%0d]", d), 32'(w.a), 32'h105);
            chk($sformatf("bank1 data1[%0d]", d), 32'(w.v), 32'h02);
            chk($sformatf("bank1 spacing[%0d]", d), 32'(w.t - pc), (d == 0) ? 32'd38 : 32'd2);
        end

        // Fill while the paced instance sits in its gap
        drive(1'b1, 2'd0, 8'h40, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, 2'd1, 8'(i), 1'b1);
        chk("full in_ready0", 32'(rdy[0]), 32'h0);
        chk("full overflow0", 32'(ovf[0]), 32'd3);
        chk("full overflow1", 32'(ovf[1]), 32'd0);
        wait_idle();

        // Overflow saturation
        drive(1'b1, 2'd2, 8'h20, 1'b1);
        for (int i = 0; i < 600; i++) begin
            p = {1'($urandom_range(0, 1)), 1'b1};
            drive(1'b1, p, 8'($urandom), 1'b1);
        end
        chk("sat overflow0", 32'(ovf[0]), 32'd255);
        chk("sat overflow1", 32'(ovf[1]), 32'd255);
        wait_idle();

        // Pointer wrap on the unpaced instance
        wlog.delete();
        ndata = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            p = 2'($urandom_range(0, 3));
            if (p[0]) ndata++;
            drive(1'b1, p, 8'($urandom), 1'b1);
            drive(1'b0, 2'd0, 8'h00, 1'b1);
        end
        wait_idle();
        chk("wrap count1", 32'(nlog(1)), 32'(ndata));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
        end
        wait_idle();

        // Reset while writes are queued behind the gap
        drive(1'b1, 2'd2, 8'h44, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, 2'd1, 8'(8'h10 + i), 1'b1);
        repeat (10) drive(1'b0, 2'd0, 8'h00, 1'b1);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        chk("midreset busy", 32'(bsy), 32'h0);
        chk("midreset wr_en", 32'(wen), 32'h0);
        wlog.delete();
        repeat (50) drive(1'b0, 2'd0, 8'h00, 1'b1);
        chk("midreset no writes0", 32'(nlog(0)), 32'd0);
        chk("midreset no writes1", 32'(nlog(1)), 32'd0);
        drive(1'b1, 2'd1, 8'h5A, 1'b1);
        repeat (5) drive(1'b0, 2'd0, 8'h00, 1'b1);
        for (int d = 0; d < 2; d++) begin
            getlog(d, 0, w);
            chk($sformatf("post-reset count[%0d]", d), 32'(nlog(d)), 32'd1);
            chk($sformatf("post-reset addr[%0d]", d), 32'(w.a), 32'h000);
            chk($sformatf("post-reset data[%0d]", d), 32'(w.v), 32'h5A);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
